// File: rtl/reaction_session_ctrl_pkg.sv
// Shared types and defaults for the reaction-timer session path.
package reaction_pkg;
  localparam int DEF_RT_W   = 14;
  localparam int DEF_MAX_RT = 9999;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_WAIT_RES, ST_GAP, ST_DONE, ST_ABORTED
  } session_state_t;
endpackage

// File: rtl/reaction_session_ctrl_if.sv
// Start/result handshake between the session sequencer and the reaction-timer FSM.
interface reaction_session_ctrl_if #(parameter int RT_W = reaction_pkg::DEF_RT_W);
  logic            trial_start;
  logic            res_valid;
  logic [RT_W-1:0] res_time;
  logic            res_late;
  logic            res_early;

  modport master (output trial_start, input res_valid, res_time, res_late, res_early);
  modport slave  (input trial_start, output res_valid, res_time, res_late, res_early);
endinterface

// File: rtl/reaction_session_ctrl_ms_down_counter.sv
// Loadable millisecond down-counter; holds at zero.
module ms_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         RESET_N,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!RESET_N)                      cnt_q <= '0;
    else if (load_i)                   cnt_q <= load_val_i;
    else if (tick_i && (cnt_q != '0))  cnt_q <= cnt_q - W'(1);
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/reaction_session_ctrl.sv
// Session sequencer: arms N_TRIALS reaction trials, retries early presses,
// and reports best/average time and late count at session end.
module reaction_session_ctrl
  import reaction_pkg::*;
#(
  parameter int N_TRIALS  = 4,
  parameter int RT_W      = DEF_RT_W,
  parameter int MAX_RT    = DEF_MAX_RT,
  parameter int GAP_MS    = 1000,
  parameter int MAX_RETRY = 3,
  localparam int IDX_W    = $clog2(N_TRIALS+1)
) (
  input  logic                    clk,
  input  logic                    RESET_N,
  input  logic                    tick_1ms,
  input  logic                    go,
  input  logic                    abort,
  reaction_session_ctrl_if.master rif,
  output logic                    busy,
  output logic [IDX_W-1:0]        trial_idx,
  output logic [RT_W-1:0]         best_rt,
  output logic [RT_W-1:0]         avg_rt,
  output logic [IDX_W-1:0]        late_cnt,
  output logic                    session_done,
  output logic                    session_abort
);
  localparam int LOG2N   = $clog2(N_TRIALS);
  localparam int SUM_W   = RT_W + LOG2N;
  localparam int RETRY_W = $clog2(MAX_RETRY+2);
  localparam int GAP_W   = (GAP_MS > 0) ? $clog2(GAP_MS+1) : 1;
  localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'((GAP_MS > 0) ? GAP_MS-1 : 0);
  localparam logic [RT_W-1:0]  MAX_T   = RT_W'(MAX_RT);

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] ARM      = ST_ARM;
  localparam logic [2:0] WAIT_RES = ST_WAIT_RES;
  localparam logic [2:0] GAP      = ST_GAP;
  localparam logic [2:0] DONE     = ST_DONE;
  localparam logic [2:0] ABORTED  = ST_ABORTED;

  logic [2:0]         state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0]   idx_q, idx_d, late_q, late_d;
  logic [RT_W-1:0]    best_q, best_d, avg_q, avg_d, t_sat;
  logic               gap_load, gap_zero;

  ms_down_counter #(.W(GAP_W)) u_gap (
    .clk(clk), .RESET_N(RESET_N), .load_i(gap_load), .load_val_i(GAP_LD),
    .tick_i(tick_1ms), .zero_o(gap_zero)
  );

  assign t_sat = (rif.res_time > MAX_T) ? MAX_T : rif.res_time;

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    retry_d  = retry_q;
    idx_d    = idx_q;
    late_d   = late_q;
    best_d   = best_q;
    avg_d    = avg_q;
    gap_load = 1'b0;
    case (state_q)
      IDLE, DONE, ABORTED: begin
        if (go && !abort) begin
          sum_d   = '0;
          retry_d = '0;
          idx_d   = '0;
          late_d  = '0;
          best_d  = MAX_T;
          avg_d   = '0;
          state_d = ARM;
        end
      end
      ARM: state_d = abort ? ABORTED : WAIT_RES;
      WAIT_RES: begin
        if (abort) state_d = ABORTED;
        else if (rif.res_valid) begin
          if (rif.res_early) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = (retry_d == RETRY_W'(MAX_RETRY+1)) ? ABORTED : GAP;
          end else begin
            if (rif.res_late) begin
              sum_d  = sum_q + SUM_W'(MAX_T);
              late_d = late_q + IDX_W'(1);
            end else begin
              sum_d  = sum_q + SUM_W'(t_sat);
              if (t_sat < best_q) best_d = t_sat;
            end
            idx_d   = idx_q + IDX_W'(1);
            retry_d = '0;
            state_d = GAP;
            if (idx_d == IDX_W'(N_TRIALS)) begin
              state_d = DONE;
              avg_d   = RT_W'(sum_d >> LOG2N);
            end
          end
          // Zero gap re-arms straight from the result cycle.
          if (state_d == GAP) begin
            if (GAP_MS == 0) state_d = ARM;
            else             gap_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (abort)                      state_d = ABORTED;
        else if (tick_1ms && gap_zero)  state_d = ARM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      sum_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      late_q  <= '0;
      best_q  <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      late_q  <= late_d;
      best_q  <= best_d;
      avg_q   <= avg_d;
    end
  end

  assign rif.trial_start = (state_q == ARM) && !abort;
  assign busy            = (state_q == ARM) || (state_q == WAIT_RES) || (state_q == GAP);
  assign trial_idx       = idx_q;
  assign best_rt         = best_q;
  assign avg_rt          = avg_q;
  assign late_cnt        = late_q;
  assign session_done    = (state_q == DONE);
  assign session_abort   = (state_q == ABORTED);
endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Directed bench for reaction_session_ctrl (N_TRIALS=4, GAP_MS=2, MAX_RETRY=3).
module tb_reaction_session_ctrl;
  localparam int RT_W  = 14;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic RESET_N, tick_1ms, go, abort;
  logic busy, session_done, session_abort;
  logic [IDX_W-1:0] trial_idx, late_cnt;
  logic [RT_W-1:0]  best_rt, avg_rt;
  int checks = 0;
  int errors = 0;

  reaction_session_ctrl_if #(.RT_W(RT_W)) rif ();

  reaction_session_ctrl #(
    .N_TRIALS(4), .RT_W(RT_W), .MAX_RT(9999), .GAP_MS(2), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .RESET_N(RESET_N), .tick_1ms(tick_1ms), .go(go), .abort(abort),
    .rif(rif), .busy(busy), .trial_idx(trial_idx), .best_rt(best_rt),
    .avg_rt(avg_rt), .late_cnt(late_cnt), .session_done(session_done),
    .session_abort(session_abort)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic result(input int t, input logic late, input logic early);
    rif.res_valid = 1'b1;
    rif.res_time  = RT_W'(t);
    rif.res_late  = late;
    rif.res_early = early;
    step();
    rif.res_valid = 1'b0;
    rif.res_late  = 1'b0;
    rif.res_early = 1'b0;
  endtask

  // Two ticks in GAP; trial_start must appear right after the second one.
  task automatic gap_chk(input string tag);
    tick_1ms = 1'b1; step(); tick_1ms = 1'b0;
    chk({tag, "_no_ts"}, 32'(rif.trial_start), 0);
    step();
    tick_1ms = 1'b1; step(); tick_1ms = 1'b0;
    chk({tag, "_ts"}, 32'(rif.trial_start), 1);
    step();
  endtask

  task automatic start_session();
    go = 1'b1; step(); go = 1'b0;
    chk("go_ts", 32'(rif.trial_start), 1);
    chk("go_best", 32'(best_rt), 9999);
    chk("go_idx", 32'(trial_idx), 0);
    chk("go_done", 32'(session_done), 0);
    step();
    chk("ts_width", 32'(rif.trial_start), 0);
  endtask

  initial begin
    RESET_N = 1'b0; go = 1'b1; abort = 1'b0; tick_1ms = 1'b0;
    rif.res_valid = 1'b0; rif.res_time = '0; rif.res_late = 1'b0; rif.res_early = 1'b0;
    step(); step();
    chk("rst_ts", 32'(rif.trial_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(trial_idx), 0);
    chk("rst_best", 32'(best_rt), 0);
    chk("rst_avg", 32'(avg_rt), 0);
    chk("rst_late", 32'(late_cnt), 0);
    chk("rst_done", 32'(session_done), 0);
    chk("rst_abort", 32'(session_abort), 0);
    go = 1'b0; RESET_N = 1'b1; step();
    chk("idle_busy", 32'(busy), 0);
    result(777, 1'b0, 1'b0);
    chk("idle_res_ign", 32'(trial_idx), 0);

    // Session 1: 300,250,400,350
    start_session();
    chk("s1_busy", 32'(busy), 1);
    result(300, 1'b0, 1'b0);
    chk("s1_idx1", 32'(trial_idx), 1);
    result(999, 1'b0, 1'b0);
    chk("s1_gap_ign", 32'(trial_idx), 1);
    gap_chk("s1g1");
    result(250, 1'b0, 1'b0); gap_chk("s1g2");
    result(400, 1'b0, 1'b0); gap_chk("s1g3");
    result(350, 1'b0, 1'b0);
    chk("s1_done", 32'(session_done), 1);
    chk("s1_best", 32'(best_rt), 250);
    chk("s1_avg", 32'(avg_rt), 325);
    chk("s1_late", 32'(late_cnt), 0);
    chk("s1_idx", 32'(trial_idx), 4);
    chk("s1_busy0", 32'(busy), 0);
    result(1, 1'b0, 1'b0);
    chk("done_res_ign_best", 32'(best_rt), 250);
    chk("done_res_ign_avg", 32'(avg_rt), 325);

    // Session 2: 200, late, 200, 200
    start_session();
    result(200, 1'b0, 1'b0); gap_chk("s2g1");
    result(0, 1'b1, 1'b0);
    chk("s2_late1", 32'(late_cnt), 1);
    gap_chk("s2g2");
    result(200, 1'b0, 1'b0); gap_chk("s2g3");
    result(200, 1'b0, 1'b0);
    chk("s2_done", 32'(session_done), 1);
    chk("s2_avg", 32'(avg_rt), 2649);
    chk("s2_best", 32'(best_rt), 200);
    chk("s2_late", 32'(late_cnt), 1);

    // Session 3: saturation, early+late treated as early
    start_session();
    result(12000, 1'b0, 1'b0);
    chk("s3_sat_best", 32'(best_rt), 9999);
    gap_chk("s3g1");
    result(50, 1'b1, 1'b1);
    chk("s3_el_idx", 32'(trial_idx), 1);
    chk("s3_el_late", 32'(late_cnt), 0);
    chk("s3_el_best", 32'(best_rt), 9999);
    gap_chk("s3g2");
    result(100, 1'b0, 1'b0); gap_chk("s3g3");
    result(100, 1'b0, 1'b0); gap_chk("s3g4");
    result(100, 1'b0, 1'b0);
    chk("s3_done", 32'(session_done), 1);
    chk("s3_avg", 32'(avg_rt), 2574);
    chk("s3_best", 32'(best_rt), 100);

    // Session 4: three earlies then 500; then four earlies abort
    start_session();
    for (int i = 0; i < 3; i++) begin
      result(10, 1'b0, 1'b1);
      chk("s4_early_busy", 32'(busy), 1);
      gap_chk("s4ge");
    end
    result(500, 1'b0, 1'b0);
    chk("s4_idx1", 32'(trial_idx), 1);
    chk("s4_best", 32'(best_rt), 500);
    gap_chk("s4g1");
    for (int i = 0; i < 3; i++) begin
      result(10, 1'b0, 1'b1);
      chk("s4_retry_clr", 32'(session_abort), 0);
      gap_chk("s4gr");
    end
    result(10, 1'b0, 1'b1);
    chk("s4_abort", 32'(session_abort), 1);
    chk("s4_abort_busy", 32'(busy), 0);
    chk("s4_abort_idx", 32'(trial_idx), 1);
    for (int i = 0; i < 4; i++) begin
      tick_1ms = 1'b1; step(); tick_1ms = 1'b0;
      chk("s4_no_ts", 32'(rif.trial_start), 0);
    end

    // Session 5: abort in WAIT_RES of trial 2, go+abort, then go
    start_session();
    result(300, 1'b0, 1'b0); gap_chk("s5g1");
    abort = 1'b1; step(); abort = 1'b0;
    chk("s5_abort", 32'(session_abort), 1);
    chk("s5_busy", 32'(busy), 0);
    chk("s5_idx", 32'(trial_idx), 1);
    chk("s5_best", 32'(best_rt), 300);
    go = 1'b1; abort = 1'b1; step(); abort = 1'b0; go = 1'b0;
    chk("s5_goab_stay", 32'(session_abort), 1);
    chk("s5_goab_ts", 32'(rif.trial_start), 0);
    go = 1'b1; step(); go = 1'b0;
    chk("s5_restart_abort", 32'(session_abort), 0);
    chk("s5_restart_best", 32'(best_rt), 9999);
    chk("s5_restart_idx", 32'(trial_idx), 0);
    chk("s5_restart_ts", 32'(rif.trial_start), 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
